bpred_update_ctrl: RTL

// Update sequencer for the bimodal branch predictor's 2-bit counter table.
// - Buffers resolved-branch updates from decode in a small FIFO.
// - Drains them one per cycle as read-modify-write saturating updates.
// - Walks the whole table writing INIT_VAL after reset or on clr_req.
// - Owns the table's single write port; the fetch-side read port is untouched.

---
 rtl/bpred_update_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bpred_update_ctrl.sv
// -----------------------------------------------------------------------------
// bpred_update_ctrl
// Update sequencer for the bimodal branch predictor's 2-bit counter table.
// Resolved-branch updates from decode are buffered in a small FIFO. They are
// drained one per cycle as read-modify-write saturating counter updates. After
// reset or a clr_req pulse the whole table is first walked and written with
// INIT_VAL. This block owns the table's only write port. The fetch-side read
// port is not touched here.
//
// Ports
//   clk, reset   clock, synchronous active-high reset
//   upd_valid    decode offers an update (upd_pc index bits, upd_taken)
//   upd_ready    update accepted when upd_valid & upd_ready
//   clr_req      one-cycle pulse: flush queue and re-initialise the table
//   tbl_wstall   table write port unavailable this cycle
//   tbl_ridx     RMW read index (FIFO head), tbl_rdata comes back same cycle
//   tbl_we/widx/wdata  table write port, captured at the next posedge
//   init_busy    initialisation walk in progress
//   upd_count    number of updates committed to the table (wraps)
// -----------------------------------------------------------------------------
module bpred_update_ctrl #(
  parameter int unsigned INDEX_SIZE = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  INIT_VAL   = 2'b10,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [31:0]           upd_pc,
  input  logic                  upd_taken,
  input  logic                  clr_req,
  input  logic                  tbl_wstall,
  output logic [INDEX_SIZE-1:0] tbl_ridx,
  input  logic [1:0]            tbl_rdata,
  output logic                  tbl_we,
  output logic [INDEX_SIZE-1:0] tbl_widx,
  output logic [1:0]            tbl_wdata,
  output logic                  init_busy,
  output logic [CNT_W-1:0]      upd_count
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [INDEX_SIZE-1:0] LAST_IDX = '1;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                state_q, state_d;
  logic [INDEX_SIZE-1:0] walk_q, walk_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           fill_q, fill_d;
  logic [CNT_W-1:0]      upd_cnt_q, upd_cnt_d;

  logic [INDEX_SIZE-1:0] fifo_idx_q [FIFO_DEPTH];
  logic                  fifo_tk_q  [FIFO_DEPTH];

  logic                  full, empty, push, drain, head_tk;
  logic [INDEX_SIZE-1:0] head_idx;
  logic                  unused_pc_bits;

  // Only the low index bits of the pc address the table.
  assign unused_pc_bits = ^upd_pc[31:INDEX_SIZE];

  assign full     = (fill_q == FULL_CNT);
  assign empty    = (fill_q == '0);
  assign head_idx = fifo_idx_q[rd_ptr_q];
  assign head_tk  = fifo_tk_q[rd_ptr_q];
  assign tbl_ridx = head_idx;

  // Readiness looks only at the current fill level. A pop in the same cycle
  // never frees a slot for a push into a full queue.
  assign upd_ready = !reset && (state_q == S_RUN) && !full && !clr_req;
  assign push      = upd_valid && upd_ready;
  assign drain     = !reset && (state_q == S_RUN) && !empty && !tbl_wstall;
  assign init_busy = reset || (state_q == S_INIT);
  assign upd_count = upd_cnt_q;

  // Write port: the init walk writes INIT_VAL. In RUN, the head entry's
  // counter is saturated up or down. The read data comes straight from the
  // table, so back-to-back updates to one index see the previous write.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_widx  = walk_q;
    tbl_wdata = INIT_VAL;
    if (!reset) begin
      if (state_q == S_INIT) begin
        tbl_we = !tbl_wstall;
      end else begin
        tbl_we   = drain;
        tbl_widx = head_idx;
        if (head_tk) tbl_wdata = (tbl_rdata == 2'd3) ? 2'd3 : tbl_rdata + 2'd1;
        else         tbl_wdata = (tbl_rdata == 2'd0) ? 2'd0 : tbl_rdata - 2'd1;
      end
    end
  end

  // Next-state logic. clr_req takes priority and flushes the queue. A drain
  // write in that same cycle still reaches the table but is not counted.
  always_comb begin
    state_d   = state_q;
    walk_d    = walk_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    upd_cnt_d = upd_cnt_q;
    if (clr_req) begin
      state_d  = S_INIT;
      walk_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else if (state_q == S_INIT) begin
      if (!tbl_wstall) begin
        walk_d = walk_q + 1'b1;
        if (walk_q == LAST_IDX) state_d = S_RUN;
      end
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (drain) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        upd_cnt_d = upd_cnt_q + 1'b1;
      end
      case ({push, drain})
        2'b10:   fill_d = fill_q + 1'b1;
        2'b01:   fill_d = fill_q - 1'b1;
        default: fill_d = fill_q;
      endcase
    end
  end

  // Control state, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_INIT;
      walk_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      upd_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      walk_q    <= walk_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      upd_cnt_q <= upd_cnt_d;
    end
  end

  // Queue storage needs no reset: an entry is only read after it is written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q] <= upd_pc[INDEX_SIZE-1:0];
      fifo_tk_q[wr_ptr_q]  <= upd_taken;
    end
  end

endmodule
